// File: rtl/adc_uart_streamer_pkg.sv
// Shared constants, TX FSM state type and byte-framing helpers for the ADC-to-UART sample path.
package adc_uart_streamer_pkg;

    localparam int SAMPLE_HDR_BIT  = 7;
    localparam int FRAME_ADC_WIDTH = 10;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    // The header bit is set only in the first byte so a host can resynchronise mid-stream.
    function automatic logic [7:0] frameByte0(input logic [FRAME_ADC_WIDTH-1:0] sample);
        logic [7:0] b;
        b                 = '0;
        b[SAMPLE_HDR_BIT] = 1'b1;
        b[2:0]            = sample[9:7];
        return b;
    endfunction

    function automatic logic [7:0] frameByte1(input logic [FRAME_ADC_WIDTH-1:0] sample);
        return {1'b0, sample[6:0]};
    endfunction

endpackage

// File: rtl/adc_uart_streamer_if.sv
// Handshake bundle between the ADC reader, the sample streamer and the UART transmitter.
interface adc_uart_streamer_if #(
    parameter int ADC_WIDTH = 10
);
    logic [ADC_WIDTH-1:0] adc_data;
    logic                 adc_available;
    logic                 adc_clear_available;
    logic [7:0]           tx_data;
    logic                 tx_enable;
    logic                 tx_available;

    modport master (
        input  adc_data,
        input  adc_available,
        input  tx_available,
        output adc_clear_available,
        output tx_data,
        output tx_enable
    );

    modport slave (
        output adc_data,
        output adc_available,
        output tx_available,
        input  adc_clear_available,
        input  tx_data,
        input  tx_enable
    );
endinterface

// File: rtl/adc_uart_streamer_sync_fifo.sv
// Single-clock FIFO with registered read data; full/empty derive from the registered level.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     LVL_FULL  = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_rdData;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_rdData;

    // A push into a full FIFO is refused even if a pop happens in the same cycle.
    assign w_doPush  = i_push && !o_full;
    assign w_doPop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_level  <= '0;
            r_rdData <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr  <= r_rdPtr + 1'b1;
                r_rdData <= r_mem[r_rdPtr];
            end
            if (w_doPush && !w_doPop) begin
                r_level <= r_level + 1'b1;
            end else if (w_doPop && !w_doPush) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_uart_streamer.sv
// Captures ADC samples into a FIFO and streams each one to the UART as a self-synchronising byte pair.
import adc_uart_streamer_pkg::*;

module adc_uart_streamer #(
    parameter int ADC_WIDTH  = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int DECIMATE   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_stream_enable,
    adc_uart_streamer_if.master         bus,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic [7:0]                  o_overflow_count
);
    tx_state_t             r_state;
    tx_state_t             w_nextState;

    logic                  r_clear;
    logic                  r_clearInFlight;
    logic                  r_push;
    logic [ADC_WIDTH-1:0]  r_pushData;
    logic [7:0]            r_decCnt;
    logic [7:0]            r_overflow;
    logic [7:0]            r_txData;
    logic                  r_secondByte;

    logic                  w_capture;
    logic                  w_pop;
    logic                  w_txEnable;
    logic                  w_loadByte0;
    logic                  w_loadByte1;
    logic                  w_fifoFull;
    logic                  w_fifoEmpty;
    logic [ADC_WIDTH-1:0]  w_rdData;

    // The reader needs a cycle to drop its flag after our pulse, so ignore it for two cycles.
    assign w_capture = bus.adc_available && !r_clear && !r_clearInFlight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clear         <= 1'b0;
            r_clearInFlight <= 1'b0;
            r_push          <= 1'b0;
            r_pushData      <= '0;
            r_decCnt        <= '0;
            r_overflow      <= '0;
        end else begin
            r_clear         <= w_capture;
            r_clearInFlight <= r_clear;
            r_push          <= w_capture && i_stream_enable && (r_decCnt == '0);
            if (w_capture) begin
                r_pushData <= bus.adc_data;
            end
            if (w_capture && i_stream_enable) begin
                r_decCnt <= (r_decCnt == 8'(DECIMATE - 1)) ? '0 : r_decCnt + 1'b1;
            end
            if (r_push && w_fifoFull && (r_overflow != 8'hFF)) begin
                r_overflow <= r_overflow + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ADC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (r_push),
        .i_wr_data (r_pushData),
        .i_pop     (w_pop),
        .o_rd_data (w_rdData),
        .o_full    (w_fifoFull),
        .o_empty   (w_fifoEmpty),
        .o_level   (o_fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_txEnable  = 1'b0;
        w_loadByte0 = 1'b0;
        w_loadByte1 = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_fifoEmpty && bus.tx_available) begin
                    w_pop       = 1'b1;
                    w_nextState = TX_LOAD;
                end
            end
            TX_LOAD: begin
                w_loadByte0 = 1'b1;
                w_nextState = TX_SEND;
            end
            TX_SEND: begin
                w_txEnable  = 1'b1;
                w_nextState = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (!bus.tx_available) begin
                    w_nextState = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (bus.tx_available) begin
                    if (!r_secondByte) begin
                        w_loadByte1 = 1'b1;
                        w_nextState = TX_SEND;
                    end else begin
                        w_nextState = TX_IDLE;
                    end
                end
            end
            default: w_nextState = TX_IDLE;
        endcase
    end

    // The FIFO read register holds the popped sample for the whole pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txData     <= '0;
            r_secondByte <= 1'b0;
        end else if (w_loadByte0) begin
            r_txData     <= frameByte0(w_rdData);
            r_secondByte <= 1'b0;
        end else if (w_loadByte1) begin
            r_txData     <= frameByte1(w_rdData);
            r_secondByte <= 1'b1;
        end
    end

    assign bus.adc_clear_available = r_clear;
    assign bus.tx_data             = r_txData;
    assign bus.tx_enable           = w_txEnable;
    assign o_overflow_count        = r_overflow;

endmodule

// File: tb/tb_adc_uart_streamer.sv
// Directed bench for adc_uart_streamer: ADC reader and UART transmitter models around two DUTs.
module tb_adc_uart_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       streamEn;
    logic       txHold;
    int         txBusyCycles;
    int         busyA;
    int         busyB;
    int         clearCountA;
    int         clearCountB;
    int         vectorCount;
    int         failCount;
    logic [7:0] txBytesA[$];
    logic [7:0] txBytesB[$];
    logic [4:0] levelA;
    logic [4:0] levelB;
    logic [7:0] ovfA;
    logic [7:0] ovfB;

    adc_uart_streamer_if busA ();
    adc_uart_streamer_if busB ();

    adc_uart_streamer #(.ADC_WIDTH(10), .FIFO_DEPTH(16), .DECIMATE(1)) dutA (
        .clk              (clk),
        .rst              (rst),
        .i_stream_enable  (streamEn),
        .bus              (busA),
        .o_fifo_level     (levelA),
        .o_overflow_count (ovfA)
    );

    adc_uart_streamer #(.ADC_WIDTH(10), .FIFO_DEPTH(16), .DECIMATE(3)) dutB (
        .clk              (clk),
        .rst              (rst),
        .i_stream_enable  (streamEn),
        .bus              (busB),
        .o_fifo_level     (levelB),
        .o_overflow_count (ovfB)
    );

    always #5 clk = ~clk;

    // Transmitter and clear-pulse monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) busyA = 0;
        else if (busA.tx_enable) begin
            txBytesA.push_back(busA.tx_data);
            busyA = txBusyCycles;
        end else if (busyA > 0) busyA = busyA - 1;
        busA.tx_available = (busyA == 0) && !txHold;
        if (busA.adc_clear_available) clearCountA++;
    end

    always @(negedge clk) begin
        if (rst) busyB = 0;
        else if (busB.tx_enable) begin
            txBytesB.push_back(busB.tx_data);
            busyB = txBusyCycles;
        end else if (busyB > 0) busyB = busyB - 1;
        busB.tx_available = (busyB == 0);
        if (busB.adc_clear_available) clearCountB++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one sample, waits for its clear pulse, then drops the flag after holdExtra cycles.
    task automatic applyStimulus(input int sel, input logic [9:0] data, input int holdExtra);
        logic seen;
        seen = 1'b0;
        if (sel == 0) begin
            busA.adc_data = data; busA.adc_available = 1'b1;
        end else begin
            busB.adc_data = data; busB.adc_available = 1'b1;
        end
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if ((sel == 0) ? busA.adc_clear_available : busB.adc_clear_available) seen = 1'b1;
        end
        checkOutput("clear_seen", {31'd0, seen}, 32'd1);
        repeat (holdExtra) @(negedge clk);
        if (sel == 0) busA.adc_available = 1'b0;
        else busB.adc_available = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic waitBytes(input int sel, input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (((sel == 0) ? txBytesA.size() : txBytesB.size()) >= n) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int clearAt;
        int txEnAt;
        int clearBase;
        vectorCount  = 0;
        failCount    = 0;
        clearCountA  = 0;
        clearCountB  = 0;
        txBusyCycles = 3;
        txHold       = 1'b0;
        streamEn     = 1'b1;
        rst          = 1'b1;
        busA.adc_data = '0; busA.adc_available = 1'b0;
        busB.adc_data = '0; busB.adc_available = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_tx_enable", {31'd0, busA.tx_enable}, 32'd0);
        checkOutput("rst_clear", {31'd0, busA.adc_clear_available}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, busA.tx_data}, 32'd0);
        checkOutput("rst_level", {27'd0, levelA}, 32'd0);
        checkOutput("rst_overflow", {24'd0, ovfA}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: single sample, latency and framing
        busA.adc_data = 10'h2AB;
        busA.adc_available = 1'b1;
        clearAt = 0;
        txEnAt  = 0;
        for (int k = 1; k <= 12 && txEnAt == 0; k++) begin
            @(negedge clk);
            if (busA.adc_clear_available && clearAt == 0) begin
                clearAt = k;
                busA.adc_available = 1'b0;
            end
            if (busA.tx_enable) txEnAt = k;
        end
        checkOutput("t1_clear_cycle", clearAt, 32'd1);
        checkOutput("t1_txen_latency", txEnAt, 32'd4);
        waitBytes(0, 2, 100);
        repeat (20) @(negedge clk);
        checkOutput("t1_byte_count", txBytesA.size(), 32'd2);
        checkOutput("t1_byte0", {24'd0, txBytesA[0]}, 32'h85);
        checkOutput("t1_byte1", {24'd0, txBytesA[1]}, 32'h2B);
        checkOutput("t1_level", {27'd0, levelA}, 32'd0);
        checkOutput("t1_clears", clearCountA, 32'd1);
        txBytesA.delete();

        // T2: fill past capacity with the transmitter stalled
        txHold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) applyStimulus(0, 10'(i), 0);
        checkOutput("t2_level_full", {27'd0, levelA}, 32'd16);
        checkOutput("t2_overflow", {24'd0, ovfA}, 32'd4);
        txHold = 1'b0;
        waitBytes(0, 32, 2000);
        repeat (20) @(negedge clk);
        checkOutput("t2_byte_count", txBytesA.size(), 32'd32);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t2_b0_%0d", i), {24'd0, txBytesA[2*i]}, 32'h80);
            checkOutput($sformatf("t2_b1_%0d", i), {24'd0, txBytesA[2*i+1]}, i);
        end
        checkOutput("t2_level_drained", {27'd0, levelA}, 32'd0);
        txBytesA.delete();

        // T3: decimate-by-3 instance
        for (int i = 1; i <= 6; i++) applyStimulus(1, 10'(i), 0);
        waitBytes(1, 4, 200);
        repeat (30) @(negedge clk);
        checkOutput("t3_byte_count", txBytesB.size(), 32'd4);
        checkOutput("t3_b0", {24'd0, txBytesB[0]}, 32'h80);
        checkOutput("t3_b1", {24'd0, txBytesB[1]}, 32'h01);
        checkOutput("t3_b2", {24'd0, txBytesB[2]}, 32'h80);
        checkOutput("t3_b3", {24'd0, txBytesB[3]}, 32'h04);
        checkOutput("t3_clears", clearCountB, 32'd6);

        // T4: stream disabled mid-pair
        txBusyCycles = 8;
        applyStimulus(0, 10'h3FF, 0);
        waitBytes(0, 1, 100);
        streamEn = 1'b0;
        checkOutput("t4_mid_pair", txBytesA.size(), 32'd1);
        applyStimulus(0, 10'h111, 0);
        applyStimulus(0, 10'h222, 0);
        waitBytes(0, 2, 200);
        repeat (40) @(negedge clk);
        checkOutput("t4_byte_count", txBytesA.size(), 32'd2);
        checkOutput("t4_byte0", {24'd0, txBytesA[0]}, 32'h87);
        checkOutput("t4_byte1", {24'd0, txBytesA[1]}, 32'h7F);
        checkOutput("t4_overflow", {24'd0, ovfA}, 32'd4);
        checkOutput("t4_level", {27'd0, levelA}, 32'd0);
        checkOutput("t4_clears", clearCountA, 32'd24);
        streamEn = 1'b1;
        txBytesA.delete();

        // T5: reset while waiting for byte0 to finish
        txHold = 1'b1;
        applyStimulus(0, 10'h155, 0);
        applyStimulus(0, 10'h0AA, 0);
        checkOutput("t5_level_pre", {27'd0, levelA}, 32'd2);
        txHold = 1'b0;
        waitBytes(0, 1, 100);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_tx_enable", {31'd0, busA.tx_enable}, 32'd0);
        checkOutput("t5_level", {27'd0, levelA}, 32'd0);
        checkOutput("t5_overflow", {24'd0, ovfA}, 32'd0);
        checkOutput("t5_tx_data", {24'd0, busA.tx_data}, 32'd0);
        repeat (3) @(negedge clk);
        txBytesA.delete();
        rst = 1'b0;
        txBusyCycles = 3;
        repeat (2) @(negedge clk);
        applyStimulus(0, 10'h0F0, 0);
        waitBytes(0, 2, 100);
        repeat (20) @(negedge clk);
        checkOutput("t5_byte_count", txBytesA.size(), 32'd2);
        checkOutput("t5_byte0", {24'd0, txBytesA[0]}, 32'h81);
        checkOutput("t5_byte1", {24'd0, txBytesA[1]}, 32'h70);
        txBytesA.delete();

        // T6: reader drops its flag late
        clearBase = clearCountA;
        applyStimulus(0, 10'h1C3, 2);
        waitBytes(0, 2, 100);
        repeat (30) @(negedge clk);
        checkOutput("t6_clears", clearCountA - clearBase, 32'd1);
        checkOutput("t6_byte_count", txBytesA.size(), 32'd2);
        checkOutput("t6_byte0", {24'd0, txBytesA[0]}, 32'h83);
        checkOutput("t6_byte1", {24'd0, txBytesA[1]}, 32'h43);
        checkOutput("t6_level", {27'd0, levelA}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
